// File: rtl/i2c_ball_slave.sv
// Write-only I2C slave that receives 3-byte ball-state frames and commits them atomically.
// SCL/SDA are oversampled on clk. The slave only ever pulls SDA low and never stretches SCL.
module i2c_ball_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h4A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [9:0] ball_y,
  output logic [7:0] ball_vy,
  output logic       is_ball_moving_left,
  output logic       ball_valid,
  output logic       is_receiving,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [1:0] byte_idx;
  logic [2:0] b0_shadow;
  logic [7:0] y_lo_shadow, vy_shadow;
  logic       commit_go;
  logic       sda_drive, err_det, byte_done;

  // Synchronizers preset to 1 (idle bus), so leaving reset never fakes a START or STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = ~scl_d & scl_s;
  assign scl_fall  = scl_d & ~scl_s;
  assign start_det = scl_d & scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_d & scl_s & ~sda_d & sda_s;
  assign byte_done = (bit_cnt == 4'd8);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    next_state   = state;
    sda_drive    = 1'b0;
    is_receiving = 1'b0;
    err_det      = 1'b0;

    case (state)
      S_ADDR_ACK: begin sda_drive = 1'b1; is_receiving = 1'b1; end
      S_DATA:     is_receiving = 1'b1;
      S_DATA_ACK: begin sda_drive = 1'b1; is_receiving = 1'b1; end
      default: ;
    endcase

    if (start_det || stop_det) begin
      // A frame counts as complete once B2's last bit has been sampled.
      err_det = ((state == S_DATA) && !((byte_idx == 2'd2) && byte_done)) ||
                ((state == S_DATA_ACK) && (byte_idx != 2'd2));
      next_state = stop_det ? S_IDLE : S_ADDR;
    end else begin
      case (state)
        S_ADDR:
          if (scl_fall && byte_done)
            next_state = (shift_reg == {SLAVE_ADDR, 1'b0}) ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK:
          if (scl_fall) next_state = S_DATA;
        S_DATA:
          if (scl_fall && byte_done) next_state = S_DATA_ACK;
        S_DATA_ACK:
          if (scl_fall) next_state = (byte_idx == 2'd2) ? S_IGNORE : S_DATA;
        default: ;
      endcase
    end
  end

  assign SDA = sda_drive ? 1'b0 : 1'bz;

  // Bit/byte counters, receive shifter and per-byte shadows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      byte_idx    <= '0;
      b0_shadow   <= '0;
      y_lo_shadow <= '0;
      vy_shadow   <= '0;
      commit_go   <= 1'b0;
    end else begin
      commit_go <= 1'b0;
      if (start_det || stop_det) begin
        bit_cnt  <= '0;
        byte_idx <= '0;
      end else begin
        case (state)
          S_ADDR, S_DATA: begin
            if (scl_rise && !byte_done) begin
              shift_reg <= {shift_reg[6:0], sda_s};
              bit_cnt   <= bit_cnt + 4'd1;
              if ((state == S_DATA) && (byte_idx == 2'd2) && (bit_cnt == 4'd7)) begin
                vy_shadow <= {shift_reg[6:0], sda_s};
                commit_go <= 1'b1;
              end
            end else if (scl_fall && byte_done && (state == S_DATA)) begin
              if (byte_idx == 2'd0) b0_shadow   <= shift_reg[2:0];
              if (byte_idx == 2'd1) y_lo_shadow <= shift_reg;
            end
          end
          S_ADDR_ACK:
            if (scl_fall) begin
              bit_cnt  <= '0;
              byte_idx <= '0;
            end
          S_DATA_ACK:
            if (scl_fall) begin
              bit_cnt <= '0;
              if (byte_idx != 2'd2) byte_idx <= byte_idx + 2'd1;
            end
          default: ;
        endcase
      end
    end
  end

  // Outputs change only on a commit, so an aborted frame never leaks partial data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_y              <= '0;
      ball_vy             <= '0;
      is_ball_moving_left <= 1'b0;
      ball_valid          <= 1'b0;
      frame_error         <= 1'b0;
    end else begin
      ball_valid  <= commit_go;
      frame_error <= err_det;
      if (commit_go) begin
        ball_y              <= {b0_shadow[1:0], y_lo_shadow};
        ball_vy             <= vy_shadow;
        is_ball_moving_left <= b0_shadow[2];
      end
    end
  end

endmodule

// File: tb/tb_i2c_ball_slave.sv
// Testbench for i2c_ball_slave: a bit-banged I2C master drives directed and random frames.
// A frame-level model predicts the ACKs, the committed ball state and the pulse counts.
module tb_i2c_ball_slave;

  localparam int Q = 25;  // clk cycles per quarter SCL period

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda_bus;
  logic [9:0] ball_y;
  logic [7:0] ball_vy;
  logic       is_ball_moving_left, ball_valid, is_receiving, frame_error;

  pullup (sda_bus);
  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  i2c_ball_slave #(.SLAVE_ADDR(7'h4A), .SYNC_STAGES(2)) dut (
    .clk                (clk),
    .reset              (reset),
    .SCL                (scl),
    .SDA                (sda_bus),
    .ball_y             (ball_y),
    .ball_vy            (ball_vy),
    .is_ball_moving_left(is_ball_moving_left),
    .ball_valid         (ball_valid),
    .is_receiving       (is_receiving),
    .frame_error        (frame_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;
  int valid_seen = 0;
  int err_seen   = 0;

  // Model of the committed ball state and of an addressed frame left open by a repeated START.
  logic [9:0] m_y = '0;
  logic [7:0] m_vy = '0;
  logic       m_left = 1'b0;
  int         m_pending_err = 0;

  always @(negedge clk) begin
    if (ball_valid === 1'b1) valid_seen++;
    if (frame_error === 1'b1) err_seen++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_low = ~b;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    s = sda_bus;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic [7:0] rd, output logic ack_low);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(d[i], s);
      rd[i] = s;
    end
    clock_bit(1'b1, s);
    ack_low = (s === 1'b0);
  endtask

  task automatic i2c_start;
    if (scl == 1'b0) begin
      sda_low = 1'b0;
      wait_clks(Q);
      scl = 1'b1;
      wait_clks(Q);
    end
    sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic i2c_stop;
    sda_low = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    sda_low = 1'b0;
    wait_clks(Q);
  endtask

  task automatic run_frame(input string name, input logic [6:0] addr, input logic rw,
                           input byte_q_t data, input bit do_stop);
    int   v0 = valid_seen;
    int   e0 = err_seen;
    int   exp_v = 0;
    int   exp_e = m_pending_err;
    bit   ok = (addr == 7'h4A) && !rw;
    logic ack;
    logic [7:0] rd, sent;

    m_pending_err = 0;
    i2c_start;
    send_byte({addr, rw}, rd, ack);
    n_checks++;
    if (ack !== ok) begin
      n_fails++;
      $display("FAIL %s addr_ack: got %0b want %0b", name, ack, ok);
    end
    n_checks++;
    if (is_receiving !== ok) begin
      n_fails++;
      $display("FAIL %s is_receiving: got %0b want %0b", name, is_receiving, ok);
    end
    foreach (data[i]) begin
      sent = rw ? 8'hFF : data[i];
      send_byte(sent, rd, ack);
      n_checks++;
      if (rd !== sent) begin
        n_fails++;
        $display("FAIL %s bus_byte%0d: got %h want %h", name, i, rd, sent);
      end
      n_checks++;
      if (ack !== (ok && i < 3)) begin
        n_fails++;
        $display("FAIL %s data_ack%0d: got %0b want %0b", name, i, ack, ok && i < 3);
      end
    end
    if (ok && data.size() >= 3) begin
      m_y    = {data[0][1:0], data[1]};
      m_left = data[0][2];
      m_vy   = data[2];
      exp_v  = 1;
    end else if (ok) begin
      if (do_stop) exp_e++;
      else m_pending_err = 1;
    end
    if (do_stop) i2c_stop;
    wait_clks(4);
    n_checks++;
    if (valid_seen - v0 !== exp_v) begin
      n_fails++;
      $display("FAIL %s valid_pulses: got %0d want %0d", name, valid_seen - v0, exp_v);
    end
    n_checks++;
    if (err_seen - e0 !== exp_e) begin
      n_fails++;
      $display("FAIL %s error_pulses: got %0d want %0d", name, err_seen - e0, exp_e);
    end
    n_checks++;
    if ({ball_y, ball_vy, is_ball_moving_left} !== {m_y, m_vy, m_left}) begin
      n_fails++;
      $display("FAIL %s outputs: got y=%h vy=%h left=%0b want y=%h vy=%h left=%0b",
               name, ball_y, ball_vy, is_ball_moving_left, m_y, m_vy, m_left);
    end
    if (do_stop) begin
      n_checks++;
      if ({is_receiving, sda_bus} !== 2'b01) begin
        n_fails++;
        $display("FAIL %s idle_bus: got rx=%0b sda=%0b want rx=0 sda=1", name, is_receiving, sda_bus);
      end
    end
  endtask

  task automatic test_reset;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(3);
    n_checks++;
    if ({ball_y, ball_vy, is_ball_moving_left, ball_valid, is_receiving, frame_error, sda_bus}
        !== {10'd0, 8'd0, 5'b00000, 1'b1}) begin
      n_fails++;
      $display("FAIL reset_state: got y=%h vy=%h l=%0b v=%0b rx=%0b err=%0b sda=%0b want zeros, sda=1",
               ball_y, ball_vy, is_ball_moving_left, ball_valid, is_receiving, frame_error, sda_bus);
    end
  endtask

  task automatic test_directed;
    byte_q_t q;
    q = {8'h06, 8'h2C, 8'hF3};
    run_frame("full_frame", 7'h4A, 1'b0, q, 1'b1);
    run_frame("wrong_addr", 7'h4B, 1'b0, q, 1'b1);
    q = {8'hFF};
    run_frame("read_req", 7'h4A, 1'b1, q, 1'b1);
    q = {8'h01, 8'h10};
    run_frame("partial", 7'h4A, 1'b0, q, 1'b1);
    q = {8'h00, 8'h05, 8'h07, 8'hAA};
    run_frame("extra_byte", 7'h4A, 1'b0, q, 1'b1);
  endtask

  task automatic test_back_to_back;
    byte_q_t q;
    q = {8'h07, 8'h3C};
    run_frame("rstart_open", 7'h4A, 1'b0, q, 1'b0);
    q = {8'h02, 8'h00, 8'h10};
    run_frame("rstart_new", 7'h4A, 1'b0, q, 1'b1);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] rd;
    logic ack, s;
    int v0;
    byte_q_t q;
    i2c_start;
    send_byte({7'h4A, 1'b0}, rd, ack);
    send_byte(8'h05, rd, ack);
    for (int i = 7; i >= 0; i--) clock_bit(1'(8'h66 >> i), s);
    sda_low = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q / 2);
    n_checks++;
    if (sda_bus !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_reset_ack: got sda=%0b want 0", sda_bus);
    end
    v0 = valid_seen;
    reset = 1'b1;
    wait_clks(1);
    m_y = '0; m_vy = '0; m_left = 1'b0;
    n_checks++;
    if ({sda_bus, ball_y, ball_vy, is_ball_moving_left, is_receiving, ball_valid, frame_error}
        !== {1'b1, 10'd0, 8'd0, 4'b0000}) begin
      n_fails++;
      $display("FAIL mid_reset_state: got sda=%0b y=%h vy=%h l=%0b rx=%0b want sda=1, zeros",
               sda_bus, ball_y, ball_vy, is_ball_moving_left, is_receiving);
    end
    wait_clks(2);
    reset = 1'b0;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
    send_byte(8'hC3, rd, ack);
    n_checks++;
    if (ack !== 1'b0) begin
      n_fails++;
      $display("FAIL mid_reset_tail_ack: got %0b want 0", ack);
    end
    i2c_stop;
    wait_clks(4);
    n_checks++;
    if ((valid_seen - v0) !== 0 || ball_y !== 10'd0) begin
      n_fails++;
      $display("FAIL mid_reset_tail: got pulses=%0d y=%h want 0, 000", valid_seen - v0, ball_y);
    end
    q = {8'h03, 8'hE1, 8'h80};
    run_frame("after_reset", 7'h4A, 1'b0, q, 1'b1);
  endtask

  task automatic test_random;
    byte_q_t q;
    logic [6:0] addr;
    logic rw;
    int n;
    for (int f = 0; f < 16; f++) begin
      addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h4A;
      rw   = ($urandom_range(0, 4) == 0);
      n    = $urandom_range(0, 5);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_frame($sformatf("rand%0d", f), addr, rw, q, 1'b1);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid_frame;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
